// File: rtl/button_cmd_controller_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// button_cmd_controller_pkg
// Shared FSM state type and default timing constants for the button controller.
// Rev 1.0
// ---------------------------------------------------------------------------
package button_cmd_controller_pkg;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  localparam int c_DEF_N_BTN         = 4;
  localparam int c_DEF_DEBOUNCE_CYC  = 10000;
  localparam int c_DEF_REPEAT_DELAY  = 200000;
  localparam int c_DEF_REPEAT_PERIOD = 50000;

endpackage
`default_nettype wire

// File: rtl/button_cmd_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// button_cmd_controller_if
// Command handshake between the controller (master) and its consumer (slave).
// Rev 1.0
// ---------------------------------------------------------------------------
interface button_cmd_controller_if #(
  parameter int N_BTN = 4
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [$clog2(N_BTN)-1:0]   cmd_id;

  modport master (output cmd_valid, output cmd_id, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_id, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/button_cmd_controller_button_channel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// button_channel
// One button: synchronizer, debounce, hold/auto-repeat timer, event strobe.
// Rev 1.0
// ---------------------------------------------------------------------------
module button_channel
  import button_cmd_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = c_DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY  = c_DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = c_DEF_REPEAT_PERIOD
) (
  input  wire  clk,
  input  wire  nrst,
  input  wire  btn_raw,
  input  wire  repeat_en,
  output logic btn_level,
  output logic evt
);

  localparam int c_DW       = $clog2(DEBOUNCE_CYC);
  localparam int c_HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_HW       = $clog2(c_HOLD_MAX + 1);

  localparam logic [c_DW-1:0] c_DEB_LAST = c_DW'(DEBOUNCE_CYC - 1);
  localparam logic [c_HW-1:0] c_DLY_LAST = c_HW'(REPEAT_DELAY - 1);
  localparam logic [c_HW-1:0] c_PER_LAST = c_HW'(REPEAT_PERIOD - 1);
  localparam logic [c_HW-1:0] c_HOLD_SAT = {c_HW{1'b1}};

  logic            r_sync1, r_sync2;
  logic [c_DW-1:0] r_deb_cnt;
  logic            r_level;
  logic [c_HW-1:0] r_hold_cnt;
  logic            r_rep_phase;

  logic            w_diff, w_flip, w_hold_act, w_hold_hit;
  logic [c_HW-1:0] w_hold_tgt;

  assign w_diff     = r_sync2 != r_level;
  assign w_flip     = w_diff && (r_deb_cnt == c_DEB_LAST);
  assign w_hold_act = r_level && repeat_en;
  // First repeat waits the long delay, later ones the shorter period.
  assign w_hold_tgt = r_rep_phase ? c_PER_LAST : c_DLY_LAST;
  assign w_hold_hit = w_hold_act && (r_hold_cnt == w_hold_tgt);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_deb_cnt <= '0;
      r_level   <= 1'b0;
    end else if (!w_diff) begin
      r_deb_cnt <= '0;
    end else if (w_flip) begin
      r_deb_cnt <= '0;
      r_level   <= ~r_level;
    end else begin
      r_deb_cnt <= r_deb_cnt + c_DW'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_hold_cnt  <= '0;
      r_rep_phase <= 1'b0;
    end else if (!w_hold_act) begin
      r_hold_cnt  <= '0;
      r_rep_phase <= 1'b0;
    end else if (w_hold_hit) begin
      r_hold_cnt  <= '0;
      r_rep_phase <= 1'b1;
    end else if (r_hold_cnt != c_HOLD_SAT) begin
      r_hold_cnt  <= r_hold_cnt + c_HW'(1);
    end
  end

  assign btn_level = r_level;
  assign evt       = (w_flip && !r_level) || w_hold_hit;

endmodule
`default_nettype wire

// File: rtl/button_cmd_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// button_cmd_controller
// Per-button channels feeding pending bits, a round-robin arbiter and the
// command presentation FSM.  Rev 1.0
// ---------------------------------------------------------------------------
module button_cmd_controller
  import button_cmd_controller_pkg::*;
#(
  parameter int N_BTN         = c_DEF_N_BTN,
  parameter int DEBOUNCE_CYC  = c_DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY  = c_DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = c_DEF_REPEAT_PERIOD
) (
  input  wire                          clk,
  input  wire                          nrst,
  input  wire  [N_BTN-1:0]             btn_raw,
  input  wire  [N_BTN-1:0]             repeat_en,
  output logic [N_BTN-1:0]             btn_level,
  output logic                         overflow,
  button_cmd_controller_if.master      cmd_if
);

  localparam int c_IW = $clog2(N_BTN);

  logic [N_BTN-1:0] w_evt;
  logic [N_BTN-1:0] w_clr;
  logic [N_BTN-1:0] r_pend;
  logic             r_ovf;
  logic [c_IW-1:0]  r_cmd_id, w_id_nx;
  logic [c_IW-1:0]  r_rr, w_rr_nx;
  logic [c_IW-1:0]  w_win;
  logic             w_any;
  state_t           r_state, w_state_nx;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_chan (
      .clk      (clk),
      .nrst     (nrst),
      .btn_raw  (btn_raw[g]),
      .repeat_en(repeat_en[g]),
      .btn_level(btn_level[g]),
      .evt      (w_evt[g])
    );
  end

  // Scan downward in offset so the nearest set bit at/after r_rr wins.
  always_comb begin
    int              j;
    logic [c_IW-1:0] idx;
    w_win = '0;
    w_any = 1'b0;
    j     = 0;
    idx   = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      j = int'(r_rr) + i;
      if (j >= N_BTN) j = j - N_BTN;
      idx = c_IW'(j);
      if (r_pend[idx]) begin
        w_win = idx;
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_id_nx    = r_cmd_id;
    w_rr_nx    = r_rr;
    w_clr      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nx   = S_PRESENT;
          w_id_nx      = w_win;
          w_clr[w_win] = 1'b1;
        end
      end
      S_PRESENT: begin
        if (cmd_if.cmd_ready) begin
          w_state_nx = S_IDLE;
          w_rr_nx    = (r_cmd_id == c_IW'(N_BTN - 1)) ? '0 : r_cmd_id + c_IW'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= S_IDLE;
      r_cmd_id <= '0;
      r_rr     <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_cmd_id <= w_id_nx;
      r_rr     <= w_rr_nx;
    end
  end

  // A fresh event on a bit being granted this edge is kept, not counted as overflow.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_evt;
      r_ovf  <= |(w_evt & r_pend & ~w_clr);
    end
  end

  assign overflow         = r_ovf;
  assign cmd_if.cmd_valid = (r_state == S_PRESENT);
  assign cmd_if.cmd_id    = r_cmd_id;

endmodule
`default_nettype wire

// File: doc/button_cmd_controller.md
BUTTON_CMD_CONTROLLER -- requirements
Module: button_cmd_controller

Interface
REQ-001 SHALL have parameter N_BTN, default 4, number of button inputs (2..8).
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 10000, consecutive stable cycles to accept a level change (>=2).
REQ-003 SHALL have parameter REPEAT_DELAY, default 200000, held cycles from press to first auto-repeat (>=1).
REQ-004 SHALL have parameter REPEAT_PERIOD, default 50000, cycles between subsequent auto-repeats (>=1).
REQ-005 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-006 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port btn_raw  input  N_BTN  asynchronous raw button levels, 1 = pressed.
REQ-008 SHALL have port repeat_en  input  N_BTN  per-button auto-repeat enable, sampled each cycle.
REQ-009 SHALL have port cmd_ready  input  1  consumer accepts command this cycle.
REQ-010 SHALL have port cmd_valid  output  1  command presented.
REQ-011 SHALL have port cmd_id  output  $clog2(N_BTN)  index of button owning the command.
REQ-012 SHALL have port btn_level  output  N_BTN  debounced button levels.
REQ-013 SHALL have port overflow  output  1  one-cycle pulse: event merged into already-pending request.

Function
REQ-014 Each btn_raw bit SHALL pass a two-flop synchronizer before any other logic.
REQ-015 Debounce: per-button counter counts consecutive cycles where synchronized value != btn_level; reset to 0 whenever equal; btn_level flips on the edge where counter == DEBOUNCE_CYC-1 and values still differ.
REQ-016 Raw level held from edge 0 SHALL appear on btn_level after edge 2+DEBOUNCE_CYC; glitches shorter than DEBOUNCE_CYC synchronized cycles SHALL never change btn_level.
REQ-017 Press event SHALL occur on the edge btn_level goes 0->1; no event on release.
REQ-018 While btn_level=1 and repeat_en=1, hold counter SHALL emit a repeat event REPEAT_DELAY cycles after the press edge, then every REPEAT_PERIOD cycles.
REQ-019 Hold counter SHALL clear on release or repeat_en=0; re-enabling mid-hold restarts at REPEAT_DELAY; counter SHALL saturate, never wrap.
REQ-020 Each event SHALL set the button's pending bit on the same edge the event occurs.
REQ-021 Event on a button whose pending bit is already set SHALL be dropped and overflow pulsed for one cycle.
REQ-022 Output FSM states IDLE, PRESENT; reset state IDLE.
REQ-023 IDLE: if any pending bit set, SHALL load cmd_id with round-robin winner (first set bit at or after rr_ptr, wrapping), clear that pending bit, assert cmd_valid, go PRESENT.
REQ-024 PRESENT: cmd_valid and cmd_id SHALL hold stable until cmd_ready=1; on that edge deassert cmd_valid, set rr_ptr = cmd_id+1 (mod N_BTN), go IDLE.
REQ-025 Minimum one idle cycle between commands; max throughput one command per two cycles.
REQ-026 Event on a bit being cleared by an IDLE load on the same edge SHALL leave the bit set (new request kept, no overflow).
REQ-027 Press-to-cmd_valid latency with no contention SHALL be 3+DEBOUNCE_CYC edges from raw change.
REQ-028 cmd_ready while IDLE SHALL be ignored.

Reset
REQ-029 nrst low SHALL immediately clear synchronizers, counters, btn_level, pending bits, rr_ptr (0), cmd_id (0), cmd_valid (0), overflow (0), FSM to IDLE.
REQ-030 Reset mid-command SHALL discard presented and pending commands; a button held through reset SHALL re-debounce and produce a fresh press event.

Structure
REQ-031 Shared package SHALL hold FSM state enum and default timing constants.
REQ-032 Per-button logic (synchronizer, debounce, hold/repeat counter, event output) SHALL be sub-module button_channel, instantiated N_BTN times; pending, arbiter and FSM in top level.

Verification (DEBOUNCE_CYC=4, REPEAT_DELAY=8, REPEAT_PERIOD=4, N_BTN=4)
REQ-033 btn_raw[2] 0->1 held, cmd_ready=1 -> btn_level[2]=1 after edge 6, cmd_valid=1 cmd_id=2 after edge 7, one command only with repeat_en=0.
REQ-034 btn_raw[0] pulses high 3 cycles -> btn_level and cmd_valid stay 0.
REQ-035 buttons 0,1,3 pressed same cycle, cmd_ready=1 -> cmd_id sequence 0,1,3, each valid one cycle, one idle cycle between.
REQ-036 button 1 held, repeat_en[1]=1, cmd_ready=0 -> cmd_valid/cmd_id=1 stable; repeat at press+8 sets pending, repeat at press+12 pulses overflow.
REQ-037 button 1 held, repeat_en=1, cmd_ready=1 -> commands at press+1, press+9, press+13, press+17; release stops them.
REQ-038 nrst low while cmd_valid=1 and pending bits set -> all outputs 0 immediately; no commands after release until new debounced press.
